// File: rtl/uart_rx_mmio_if.sv
// CPU-side register bus of the memory-mapped UART receiver: select, strobes, data and interrupt.
interface uart_rx_mmio_if;
  logic        cs;
  logic        re;
  logic        we;
  logic        reg_sel;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        intr;

  modport master (
    output cs, re, we, reg_sel, i_data,
    input  o_data, intr
  );

  modport slave (
    input  cs, re, we, reg_sel, i_data,
    output o_data, intr
  );
endinterface

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receiver: 8N1 deserialiser feeding a byte FIFO with DATA/STATUS registers.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors in STATUS[4].
module uart_rx_mmio #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rx_in,
  uart_rx_mmio_if.slave  bus
);

  localparam int unsigned Div    = CLK_HZ / BAUD;
  localparam int unsigned Half   = Div / 2;
  localparam int unsigned CntW   = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned DepthW = $clog2(FIFO_DEPTH);

  localparam logic [CntW-1:0]   DivLast  = CntW'(Div - 1);
  localparam logic [CntW-1:0]   HalfLast = CntW'(Half - 1);
  localparam logic [DepthW:0]   CntFull  = (DepthW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q;
  logic              sync1_q, rx_s_q;
  logic [1:0]        sync_vld_q;
  logic              armed_q;
  logic [CntW-1:0]   clk_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shreg_q;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [DepthW-1:0] rd_ptr_q, wr_ptr_q;
  logic [DepthW:0]   count_q;
  logic              ovr_q, fe_q, ie_q;

  logic empty, full, tick, stop_smp, push_req, push, pop, wr_stat, par_bad;
  logic [31:0] status;
  logic unused_wdata;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, pe_q;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntFull);
  assign tick     = (state_q == StStart) ? (clk_cnt_q == HalfLast) : (clk_cnt_q == DivLast);
  assign stop_smp = (state_q == StStop) && tick;
  assign push_req = stop_smp && rx_s_q && !par_bad;
  assign pop      = bus.cs && bus.re && !bus.reg_sel && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push     = push_req && (!full || pop);
  assign wr_stat  = bus.cs && bus.we && bus.reg_sel;

  assign unused_wdata = ^{bus.i_data[30:4], bus.i_data[1:0]};

  // armed_q is the delayed line level, held low until the synchroniser carries real data,
  // so a line already low at reset release needs a high-then-low before a start is taken.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      sync_vld_q <= 2'b00;
      armed_q    <= 1'b0;
      state_q    <= StIdle;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
    end else begin
      sync1_q    <= rx_in;
      rx_s_q     <= sync1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      armed_q    <= rx_s_q && sync_vld_q[1];
      clk_cnt_q  <= (tick || state_q == StIdle) ? '0 : clk_cnt_q + CntW'(1);
      case (state_q)
        StIdle: begin
          if (armed_q && !rx_s_q) begin
            state_q   <= StStart;
            bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
          end
        end
        StStart: begin
          if (tick) state_q <= rx_s_q ? StIdle : StData;
        end
        StData: begin
          if (tick) begin
            shreg_q   <= {rx_s_q, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt_q == 3'd7) state_q <= StParity;
`else
            if (bit_cnt_q == 3'd7) state_q <= StStop;
`endif
          end
        end
        StParity: begin
`ifdef UART_RX_PARITY_EN
          if (tick) begin
            par_bad_q <= ^{shreg_q, rx_s_q};
            state_q   <= StStop;
          end
`else
          state_q <= StIdle;
`endif
        end
        StStop: begin
          if (tick) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= shreg_q;
  end

  // Error flags are write-1-to-clear; a new error in the same cycle wins over the clear.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
      ie_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q     <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + DepthW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + DepthW'(1);
      if (push && !pop)      count_q <= count_q + (DepthW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (DepthW + 1)'(1);
      ovr_q <= (push_req && full && !pop) || (ovr_q && !(wr_stat && bus.i_data[2]));
      fe_q  <= (stop_smp && !rx_s_q) || (fe_q && !(wr_stat && bus.i_data[3]));
`ifdef UART_RX_PARITY_EN
      pe_q  <= (stop_smp && par_bad) || (pe_q && !(wr_stat && bus.i_data[4]));
`endif
      if (wr_stat) ie_q <= bus.i_data[31];
    end
  end

  always_comb begin
    status                 = '0;
    status[0]              = !empty;
    status[1]              = full;
    status[2]              = ovr_q;
    status[3]              = fe_q;
`ifdef UART_RX_PARITY_EN
    status[4]              = pe_q;
`endif
    status[8 +: DepthW+1]  = count_q;
    status[31]             = ie_q;
    if (bus.reg_sel)  bus.o_data = status;
    else if (empty)   bus.o_data = '0;
    else              bus.o_data = {24'b0, mem_q[rd_ptr_q]};
  end

  assign bus.intr = ie_q && !empty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: drives 8N1 frames and checks the CPU view against a byte scoreboard.
module tb_uart_rx_mmio;
  localparam int unsigned ClkHz = 1_000_000;
  localparam int unsigned Baud  = 62_500;
  localparam int unsigned Div   = ClkHz / Baud;
  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_rx_mmio_if bus ();

  uart_rx_mmio #(
    .CLK_HZ    (ClkHz),
    .BAUD      (Baud),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rx_in (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  sb [$];
  bit          m_ie, m_ovr, m_fe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (sb.size() != 0);
    s[1]     = (sb.size() == Depth);
    s[2]     = m_ovr;
    s[3]     = m_fe;
    s[8 +: 5] = 5'(sb.size());
    s[31]    = m_ie;
    return s;
  endfunction

  // Frame starts one clock after the first edge seen by the task (called P0 below).
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit model_it);
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (Div) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (Div) @(posedge clk);
    #1 rx = stop_ok;
    repeat (Div) @(posedge clk);
    #1 rx = 1'b1;
    if (model_it) begin
      if (!stop_ok)                m_fe = 1'b1;
      else if (sb.size() < Depth)  sb.push_back(b);
      else                         m_ovr = 1'b1;
    end
  endtask

  task automatic cpu_read_data(input string tag);
    logic [31:0] exp;
    @(posedge clk); #1 bus.cs = 1'b1; bus.re = 1'b1; bus.reg_sel = 1'b0;
    #1 exp = (sb.size() != 0) ? {24'b0, sb.pop_front()} : 32'h0;
    check(tag, bus.o_data, exp);
    @(posedge clk); #1 bus.cs = 1'b0; bus.re = 1'b0; bus.reg_sel = 1'b1;
  endtask

  task automatic check_status(input string tag);
    @(posedge clk); #1 bus.cs = 1'b1; bus.re = 1'b1; bus.reg_sel = 1'b1;
    #1 check(tag, bus.o_data, exp_status());
    check({tag, "_intr"}, {31'b0, bus.intr}, {31'b0, m_ie && (sb.size() != 0)});
    @(posedge clk); #1 bus.cs = 1'b0; bus.re = 1'b0;
  endtask

  task automatic write_reg(input logic sel, input logic [31:0] val);
    @(posedge clk); #1 bus.cs = 1'b1; bus.we = 1'b1; bus.reg_sel = sel; bus.i_data = val;
    @(posedge clk); #1 bus.cs = 1'b0; bus.we = 1'b0; bus.reg_sel = 1'b1; bus.i_data = '0;
    if (sel) begin
      m_ie = val[31];
      if (val[2]) m_ovr = 1'b0;
      if (val[3]) m_fe  = 1'b0;
    end
  endtask

  initial begin
    bus.cs = 1'b0; bus.re = 1'b0; bus.we = 1'b0; bus.reg_sel = 1'b1; bus.i_data = '0;
    m_ie = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    check_status("reset_status");
    cpu_read_data("reset_data_empty");

    // 1: single byte; stop sample lands on P155, byte visible right after it.
    fork
      send_byte(8'hA5, 1'b1, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #2 check("t1_before_push", bus.o_data, 32'h0);
        @(posedge clk);
        #2 check("t1_after_push", bus.o_data, 32'h0000_0101);
      end
    join
    check_status("t1_status");
    cpu_read_data("t1_data");
    check_status("t1_status_empty");
    write_reg(1'b0, 32'h0000_00FF);
    check_status("t1_data_write_ignored");

    // 2: interrupt follows the push by one cycle and drops after the pop.
    write_reg(1'b1, 32'h8000_0000);
    fork
      send_byte(8'h3C, 1'b1, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #2 check("t2_intr_before", {31'b0, bus.intr}, 32'h0);
        @(posedge clk);
        #2 check("t2_intr_rise", {31'b0, bus.intr}, 32'h1);
      end
    join
    cpu_read_data("t2_data");
    check("t2_intr_fall", {31'b0, bus.intr}, 32'h0);

    // 3: overflow on the 17th byte.
    for (int b = 0; b <= 16; b++) send_byte(8'(b), 1'b1, 1'b1);
    check_status("t3_full_ovr");
    for (int i = 0; i < 16; i++) cpu_read_data($sformatf("t3_read_%0d", i));
    write_reg(1'b1, 32'h8000_0004);
    check_status("t3_ovr_cleared");

    // 4: short glitch is rejected; a bad stop bit sets fe and drops the byte.
    @(posedge clk); #1 rx = 1'b0;
    repeat (Div / 4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * Div) @(posedge clk);
    check_status("t4_glitch");
    send_byte(8'h55, 1'b0, 1'b1);
    repeat (Div) @(posedge clk);
    check_status("t4_fe");
    write_reg(1'b1, 32'h8000_0008);
    check_status("t4_fe_cleared");

    // 5: full FIFO, pop in the same cycle as the push of 0x77.
    for (int i = 0; i < 16; i++) send_byte(8'hE0 + 8'(i), 1'b1, 1'b1);
    check_status("t5_full");
    fork
      send_byte(8'h77, 1'b1, 1'b1);
      begin
        @(posedge clk);
        repeat (153) @(posedge clk);
        cpu_read_data("t5_pop_with_push");
      end
    join
    check_status("t5_count_kept");
    for (int i = 0; i < 16; i++) cpu_read_data($sformatf("t5_read_%0d", i));
    check_status("t5_drained");

    // 6: reset during data bit 4; the rest of the frame stays low, so nothing is received.
    fork
      send_byte(8'h0F, 1'b1, 1'b0);
      begin
        @(posedge clk);
        repeat (88) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        m_ie = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
      end
    join
    repeat (Div) @(posedge clk);
    check_status("t6_after_abort");
    send_byte(8'h81, 1'b1, 1'b1);
    check_status("t6_status");
    cpu_read_data("t6_data");
    check_status("t6_empty");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
